// File: rtl/cpu_defs.sv
// Shared CPU definitions: TLB entry layout, probe result and CP0 TLB opcodes.
package cpu_defs;

  localparam int unsigned TLB_ENTRIES_NUM = 16;
  // Wide enough for any supported TLB size (up to 256 entries).
  localparam int unsigned TLB_IDX_W       = 8;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic                 hit;
    logic [TLB_IDX_W-1:0] index;
  } tlb_result_t;

endpackage

// File: rtl/tlb_lookup.sv
// Fully associative TLB match on {vpn2, asid}; lowest matching index wins.
module tlb_lookup
  import cpu_defs::*;
#(
  parameter int unsigned ENTRIES = TLB_ENTRIES_NUM
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  logic [18:0]              vpn2,
  input  logic [7:0]               asid,
  output tlb_result_t              result
);

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      // PageMask bits widen the page, so those vpn2 bits are don't-care.
      if (((entries[i].vpn2 ^ vpn2) & ~{7'b0, entries[i].mask}) == '0 &&
          (entries[i].g || entries[i].asid == asid) && !result.hit) begin
        result.hit   = 1'b1;
        result.index = TLB_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// TLB owner: sequences TLBP/TLBR/TLBWI/TLBWR over IDLE/EXEC/RESP and keeps Random/Wired.
module tlb_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned ENTRIES = TLB_ENTRIES_NUM,
  parameter int unsigned IW      = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  tlb_op_t                  cmd_op,
  input  logic [IW-1:0]            cmd_index,
  input  tlb_entry_t               cmd_entry,
  input  logic                     wired_we,
  input  logic [IW-1:0]            wired_val,
  output logic                     resp_valid,
  output tlb_op_t                  resp_op,
  output logic [IW-1:0]            resp_index,
  output logic                     resp_miss,
  output tlb_entry_t               resp_entry,
  output logic [IW-1:0]            random,
  output logic                     tlb_changed,
  output tlb_entry_t [ENTRIES-1:0] entries
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [IW-1:0] IDX_MAX = IW'(ENTRIES - 1);

  state_t        state;
  tlb_op_t       op_q;
  logic [IW-1:0] idx_q;
  tlb_entry_t    ent_q;
  logic [IW-1:0] wired;
  tlb_result_t   probe;

  tlb_lookup #(
    .ENTRIES(ENTRIES)
  ) u_probe (
    .entries(entries),
    .vpn2   (ent_q.vpn2),
    .asid   (ent_q.asid),
    .result (probe)
  );

  // Random sweeps down to Wired and reloads; a Wired write restarts it at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      wired  <= '0;
      random <= IDX_MAX;
    end else if (wired_we) begin
      wired  <= wired_val;
      random <= IDX_MAX;
    end else if (random == wired) begin
      random <= IDX_MAX;
    end else begin
      random <= random - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      op_q        <= TLBP;
      idx_q       <= '0;
      ent_q       <= '0;
      resp_valid  <= 1'b0;
      resp_op     <= TLBP;
      resp_index  <= '0;
      resp_miss   <= 1'b0;
      resp_entry  <= '0;
      tlb_changed <= 1'b0;
      entries     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            ent_q     <= cmd_entry;
            // TLBWR targets whatever Random holds in the accept cycle.
            idx_q     <= (cmd_op == TLBWR) ? random : cmd_index;
            cmd_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_valid <= 1'b1;
          resp_op    <= op_q;
          state      <= S_RESP;
          case (op_q)
            TLBWI, TLBWR: begin
              entries[idx_q] <= ent_q;
              tlb_changed    <= 1'b1;
            end
            TLBR: resp_entry <= entries[idx_q];
            TLBP: begin
              resp_miss  <= ~probe.hit;
              resp_index <= probe.hit ? IW'(probe.index) : '0;
            end
            default: ;
          endcase
        end
        S_RESP: begin
          resp_valid  <= 1'b0;
          resp_op     <= TLBP;
          resp_index  <= '0;
          resp_miss   <= 1'b0;
          resp_entry  <= '0;
          tlb_changed <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: reset, write/probe, ASID/global match, Random/Wired, TLBR, reset abort.
module tb_tlb_ctrl;
  import cpu_defs::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  tlb_op_t             cmd_op;
  logic [3:0]          cmd_index;
  tlb_entry_t          cmd_entry;
  logic                wired_we;
  logic [3:0]          wired_val;
  logic                resp_valid;
  tlb_op_t             resp_op;
  logic [3:0]          resp_index;
  logic                resp_miss;
  tlb_entry_t          resp_entry;
  logic [3:0]          random;
  logic                tlb_changed;
  tlb_entry_t [15:0]   entries;

  int tests = 0;
  int fails = 0;

  // Reference Random/Wired behaviour, advanced on every clock edge.
  logic [3:0] m_rand;
  logic [3:0] m_wired;

  // Values captured by do_cmd in EXEC and RESP.
  logic              ex_ready, ex_valid;
  tlb_entry_t [15:0] ex_ent;
  logic              r_valid, r_miss, r_changed;
  tlb_op_t           r_op;
  logic [3:0]        r_index, acc_rand;
  tlb_entry_t        r_entry;
  tlb_entry_t [15:0] r_ent;

  tlb_entry_t e5, e5g, e9;

  always #5 clk = ~clk;

  tlb_ctrl #(
    .ENTRIES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_index  (cmd_index),
    .cmd_entry  (cmd_entry),
    .wired_we   (wired_we),
    .wired_val  (wired_val),
    .resp_valid (resp_valid),
    .resp_op    (resp_op),
    .resp_index (resp_index),
    .resp_miss  (resp_miss),
    .resp_entry (resp_entry),
    .random     (random),
    .tlb_changed(tlb_changed),
    .entries    (entries)
  );

  always @(posedge clk) begin
    if (rst) begin
      m_rand  <= 4'd15;
      m_wired <= 4'd0;
    end else if (wired_we) begin
      m_wired <= wired_val;
      m_rand  <= 4'd15;
    end else if (m_rand == m_wired) begin
      m_rand <= 4'd15;
    end else begin
      m_rand <= m_rand - 4'd1;
    end
  end

  function automatic tlb_entry_t mk(input logic [18:0] v, input logic [7:0] a,
                                    input logic g, input logic [19:0] p);
    tlb_entry_t e;
    e      = '0;
    e.vpn2 = v;
    e.asid = a;
    e.g    = g;
    e.pfn0 = p;
    e.d0   = 1'b1;
    e.v0   = 1'b1;
    e.pfn1 = p + 20'd1;
    e.v1   = 1'b1;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the IDLE cycle after RESP.
  task automatic do_cmd(input tlb_op_t op, input logic [3:0] idx, input tlb_entry_t ent);
    int unsigned n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    acc_rand  = m_rand;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = idx;
    cmd_entry = ent;
    @(negedge clk);
    cmd_valid = 1'b0;
    ex_ready  = cmd_ready;
    ex_valid  = resp_valid;
    ex_ent    = entries;
    @(negedge clk);
    r_valid   = resp_valid;
    r_op      = resp_op;
    r_index   = resp_index;
    r_miss    = resp_miss;
    r_entry   = resp_entry;
    r_changed = tlb_changed;
    r_ent     = entries;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = TLBP; cmd_index = '0; cmd_entry = '0;
    wired_we = 1'b0; wired_val = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++; if (random !== 4'd15) begin fails++; $display("FAIL reset_random: got %0d want 15", random); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    tests++;
    if ({resp_valid, resp_op, resp_index, resp_miss, tlb_changed} !== '0 || resp_entry !== '0) begin
      fails++;
      $display("FAIL reset_resp: valid=%b op=%0d idx=%0d miss=%b chg=%b entry=%h want all 0",
               resp_valid, resp_op, resp_index, resp_miss, tlb_changed, resp_entry);
    end
    tests++; if (entries !== '0) begin fails++; $display("FAIL reset_entries: got nonzero want 0"); end
    @(negedge clk);
    tests++; if (random !== 4'd14) begin fails++; $display("FAIL random_idle1: got %0d want 14", random); end
    @(negedge clk);
    tests++; if (random !== 4'd13) begin fails++; $display("FAIL random_idle2: got %0d want 13", random); end
  endtask

  task automatic test_write_probe;
    e5 = mk(19'h12345, 8'd3, 1'b0, 20'hABC);
    do_cmd(TLBWI, 4'd5, e5);
    tests++; if (ex_ready !== 1'b0 || ex_valid !== 1'b0) begin fails++; $display("FAIL wi_exec: ready=%b valid=%b want 0 0", ex_ready, ex_valid); end
    tests++; if (ex_ent[5] !== '0) begin fails++; $display("FAIL wi_early_write: entries[5]=%h want 0", ex_ent[5]); end
    tests++;
    if (r_valid !== 1'b1 || r_changed !== 1'b1 || r_op !== TLBWI) begin
      fails++;
      $display("FAIL wi_resp: valid=%b changed=%b op=%0d want 1 1 2", r_valid, r_changed, r_op);
    end
    tests++; if (r_ent[5] !== e5) begin fails++; $display("FAIL wi_visible: entries[5]=%h want %h", r_ent[5], e5); end
    tests++; if (r_index !== 4'd0 || r_miss !== 1'b0) begin fails++; $display("FAIL wi_fields: idx=%0d miss=%b want 0 0", r_index, r_miss); end

    do_cmd(TLBP, 4'd0, mk(19'h12345, 8'd3, 1'b0, 20'h0));
    tests++;
    if (r_valid !== 1'b1 || r_index !== 4'd5 || r_miss !== 1'b0 || r_changed !== 1'b0) begin
      fails++;
      $display("FAIL probe_hit: valid=%b idx=%0d miss=%b chg=%b want 1 5 0 0", r_valid, r_index, r_miss, r_changed);
    end
    tests++; if (r_entry !== '0) begin fails++; $display("FAIL probe_entry: got %h want 0", r_entry); end
  endtask

  task automatic test_asid_global;
    do_cmd(TLBP, 4'd0, mk(19'h12345, 8'd4, 1'b0, 20'h0));
    tests++;
    if (r_miss !== 1'b1 || r_index !== 4'd0) begin
      fails++;
      $display("FAIL probe_asid_miss: miss=%b idx=%0d want 1 0", r_miss, r_index);
    end
    e5g = mk(19'h12345, 8'd3, 1'b1, 20'hABC);
    do_cmd(TLBWI, 4'd5, e5g);
    do_cmd(TLBP, 4'd0, mk(19'h12345, 8'd4, 1'b0, 20'h0));
    tests++;
    if (r_miss !== 1'b0 || r_index !== 4'd5) begin
      fails++;
      $display("FAIL probe_global: miss=%b idx=%0d want 0 5", r_miss, r_index);
    end
    e9 = mk(19'h12345, 8'd3, 1'b0, 20'h999);
    do_cmd(TLBWI, 4'd9, e9);
    do_cmd(TLBP, 4'd0, mk(19'h12345, 8'd3, 1'b0, 20'h0));
    tests++;
    if (r_miss !== 1'b0 || r_index !== 4'd5) begin
      fails++;
      $display("FAIL probe_lowest: miss=%b idx=%0d want 0 5", r_miss, r_index);
    end
    // Clear index 9 again so it does not shadow later checks.
    do_cmd(TLBWI, 4'd9, '0);
  endtask

  task automatic test_random_wired;
    logic [3:0]  walk [7];
    tlb_entry_t  e;
    walk = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd15};
    wired_we  = 1'b1;
    wired_val = 4'd10;
    @(negedge clk);
    wired_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (random !== walk[i]) begin fails++; $display("FAIL random_walk%0d: got %0d want %0d", i, random, walk[i]); end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (i % 2) @(negedge clk);
      e = mk(19'h40000 + 19'(i), 8'd1, 1'b0, 20'h100 + 20'(i));
      do_cmd(TLBWR, 4'd0, e);
      tests++;
      if (acc_rand < 4'd10 || r_ent[acc_rand] !== e || r_changed !== 1'b1) begin
        fails++;
        $display("FAIL tlbwr%0d: entries[%0d]=%h changed=%b want %h 1", i, acc_rand, r_ent[acc_rand], r_changed, e);
      end
    end
    tests++;
    if (entries[4:0] !== '0 || entries[9:6] !== '0 || entries[5] !== e5g) begin
      fails++;
      $display("FAIL tlbwr_below_wired: entries[9:0] disturbed, entries[5]=%h want %h", entries[5], e5g);
    end
    tests++; if (random !== m_rand) begin fails++; $display("FAIL random_track: got %0d want %0d", random, m_rand); end
  endtask

  task automatic test_read_and_busy;
    cmd_valid = 1'b1;
    cmd_op    = TLBR;
    cmd_index = 4'd5;
    cmd_entry = '0;
    @(negedge clk);
    cmd_op    = TLBWI;
    cmd_index = 4'd6;
    cmd_entry = mk(19'h7, 8'd7, 1'b0, 20'h7);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_exec_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL busy_resp_ready: got %b want 0", cmd_ready); end
    tests++;
    if (resp_valid !== 1'b1 || resp_op !== TLBR || resp_entry !== e5g || tlb_changed !== 1'b0) begin
      fails++;
      $display("FAIL tlbr_resp: valid=%b op=%0d chg=%b entry=%h want 1 1 0 %h", resp_valid, resp_op, tlb_changed, resp_entry, e5g);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (entries[6] !== '0 || resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL busy_ignored: entries[6]=%h valid=%b ready=%b want 0 0 1", entries[6], resp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1;
    cmd_op    = TLBWI;
    cmd_index = 4'd7;
    cmd_entry = mk(19'h55555, 8'd2, 1'b0, 20'h777);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    tests++;
    if (entries[7] !== '0 || resp_valid !== 1'b0 || tlb_changed !== 1'b0) begin
      fails++;
      $display("FAIL rst_exec: entries[7]=%h valid=%b chg=%b want 0 0 0", entries[7], resp_valid, tlb_changed);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || resp_valid !== 1'b0 || entries[7] !== '0) begin
      fails++;
      $display("FAIL rst_idle: ready=%b valid=%b entries[7]=%h want 1 0 0", cmd_ready, resp_valid, entries[7]);
    end
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_no_resp: valid=%b want 0", resp_valid); end
  endtask

  initial begin
    test_reset;
    test_write_probe;
    test_asid_global;
    test_random_wired;
    test_read_and_busy;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
